// File: rtl/ofs_plat_axi_rsp_buf_pkg.sv
// Shared types and width helpers for the AXI response credit buffer.
package ofs_plat_axi_rsp_buf_pkg;

  localparam int DEFAULT_CREDIT_BATCH = 8;

  // Width of a credit-return count able to hold 0..batch inclusive.
  function automatic int credit_cnt_w(input int batch);
    return $clog2(batch + 1);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 1) && ((n & (n - 1)) == 0);
  endfunction

  localparam int CREDIT_CNT_W = $clog2(DEFAULT_CREDIT_BATCH + 1);

  typedef logic [CREDIT_CNT_W-1:0] t_credit_cnt;

  typedef struct packed {
    logic        valid;
    t_credit_cnt cnt;
  } t_credit_ret;

endpackage

// File: rtl/ofs_plat_axi_rsp_buf_chan.sv
// One response channel: buffer, occupancy, batched credit return, overflow flag.
// Overflow detection is built only when OFS_PLAT_AXI_RSP_BUF_OVERFLOW_CHECK_EN is defined.
module ofs_plat_axi_rsp_buf_chan
  import ofs_plat_axi_rsp_buf_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int WIDTH        = 64,
  parameter int CREDIT_BATCH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   in_valid,
  input  logic [WIDTH-1:0]                       in_data,
  output logic                                   out_valid,
  output logic [WIDTH-1:0]                       out_data,
  input  logic                                   out_ready,
  output logic                                   credit_ret_valid,
  output logic [credit_cnt_w(CREDIT_BATCH)-1:0]  credit_ret_cnt,
  output logic                                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = credit_cnt_w(CREDIT_BATCH);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (CREDIT_BATCH < 1) begin : g_batch_check
    $error("CREDIT_BATCH must be at least 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] acc, sum;
  logic             deq, full, enq, fire;

  // Handshake: a beat moves on a cycle where out_valid && out_ready; out_valid
  // never drops and out_data never changes until that happens. The input side
  // has no ready and is accepted whenever space exists or a pop frees a slot.
  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];
  assign deq       = out_valid && out_ready;
  assign full      = (occ == OCC_W'(DEPTH));
  assign enq       = in_valid && (!full || deq);

  // Return a full batch immediately, or flush a partial batch once pops pause.
  assign sum  = acc + CNT_W'(deq);
  assign fire = (sum == CNT_W'(CREDIT_BATCH)) || (!deq && (acc != '0));

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      acc              <= '0;
      credit_ret_valid <= 1'b0;
      credit_ret_cnt   <= '0;
    end else begin
      wr_ptr           <= wr_ptr + PTR_W'(enq);
      rd_ptr           <= rd_ptr + PTR_W'(deq);
      occ              <= occ + OCC_W'(enq) - OCC_W'(deq);
      acc              <= fire ? '0 : sum;
      credit_ret_valid <= fire;
      credit_ret_cnt   <= fire ? sum : '0;
    end
  end

`ifdef OFS_PLAT_AXI_RSP_BUF_OVERFLOW_CHECK_EN
  logic ovf_evt;
  assign ovf_evt = in_valid && full && !deq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
  end

  overflow_never: assert property (@(posedge clk) disable iff (!reset_n) !ovf_evt)
    else $fatal(1, "%m: response arrived while buffer full");
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/ofs_plat_axi_mem_rsp_credit_buffer.sv
// Buffers R and B responses from a flow-control-free device and returns credits in batches.
// Overflow flags are live only when OFS_PLAT_AXI_RSP_BUF_OVERFLOW_CHECK_EN is defined.
module ofs_plat_axi_mem_rsp_credit_buffer
  import ofs_plat_axi_rsp_buf_pkg::*;
#(
  parameter int RD_ENTRIES   = 256,
  parameter int WR_ENTRIES   = 128,
  parameter int R_WIDTH      = 64,
  parameter int B_WIDTH      = 8,
  parameter int CREDIT_BATCH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_rvalid,
  input  logic [R_WIDTH-1:0]                    in_r,
  input  logic                                  in_bvalid,
  input  logic [B_WIDTH-1:0]                    in_b,
  output logic                                  out_rvalid,
  output logic [R_WIDTH-1:0]                    out_r,
  input  logic                                  out_rready,
  output logic                                  out_bvalid,
  output logic [B_WIDTH-1:0]                    out_b,
  input  logic                                  out_bready,
  output logic                                  rd_credit_ret_valid,
  output logic [$clog2(CREDIT_BATCH+1)-1:0]     rd_credit_ret_cnt,
  output logic                                  wr_credit_ret_valid,
  output logic [$clog2(CREDIT_BATCH+1)-1:0]     wr_credit_ret_cnt,
  output logic                                  rd_overflow,
  output logic                                  wr_overflow
);

  ofs_plat_axi_rsp_buf_chan #(
    .DEPTH        (RD_ENTRIES),
    .WIDTH        (R_WIDTH),
    .CREDIT_BATCH (CREDIT_BATCH)
  ) u_rd_chan (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_rvalid),
    .in_data          (in_r),
    .out_valid        (out_rvalid),
    .out_data         (out_r),
    .out_ready        (out_rready),
    .credit_ret_valid (rd_credit_ret_valid),
    .credit_ret_cnt   (rd_credit_ret_cnt),
    .overflow         (rd_overflow)
  );

  ofs_plat_axi_rsp_buf_chan #(
    .DEPTH        (WR_ENTRIES),
    .WIDTH        (B_WIDTH),
    .CREDIT_BATCH (CREDIT_BATCH)
  ) u_wr_chan (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_bvalid),
    .in_data          (in_b),
    .out_valid        (out_bvalid),
    .out_data         (out_b),
    .out_ready        (out_bready),
    .credit_ret_valid (wr_credit_ret_valid),
    .credit_ret_cnt   (wr_credit_ret_cnt),
    .overflow         (wr_overflow)
  );

endmodule

// File: tb/tb_ofs_plat_axi_mem_rsp_credit_buffer.sv
// Bench for ofs_plat_axi_mem_rsp_credit_buffer: queue model plus run-length credit prediction.
module tb_ofs_plat_axi_mem_rsp_credit_buffer;

  localparam int RD = 256;
  localparam int WR = 128;
  localparam int RW = 64;
  localparam int BW = 8;
  localparam int CB = 8;
  localparam int CW = $clog2(CB + 1);

  logic          clk;
  logic          reset_n;
  logic          in_rvalid, in_bvalid;
  logic [RW-1:0] in_r, out_r;
  logic [BW-1:0] in_b, out_b;
  logic          out_rvalid, out_rready, out_bvalid, out_bready;
  logic          rd_credit_ret_valid, wr_credit_ret_valid;
  logic [CW-1:0] rd_credit_ret_cnt, wr_credit_ret_cnt;
  logic          rd_overflow, wr_overflow;

  ofs_plat_axi_mem_rsp_credit_buffer #(
    .RD_ENTRIES(RD), .WR_ENTRIES(WR), .R_WIDTH(RW), .B_WIDTH(BW), .CREDIT_BATCH(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_rvalid(in_rvalid), .in_r(in_r), .in_bvalid(in_bvalid), .in_b(in_b),
    .out_rvalid(out_rvalid), .out_r(out_r), .out_rready(out_rready),
    .out_bvalid(out_bvalid), .out_b(out_b), .out_bready(out_bready),
    .rd_credit_ret_valid(rd_credit_ret_valid), .rd_credit_ret_cnt(rd_credit_ret_cnt),
    .wr_credit_ret_valid(wr_credit_ret_valid), .wr_credit_ret_cnt(wr_credit_ret_cnt),
    .rd_overflow(rd_overflow), .wr_overflow(wr_overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: FIFO contents, consecutive-pop run lengths, expected pulses.
  logic [RW-1:0] rq[$];
  logic [BW-1:0] bq[$];
  int r_run, b_run, r_exp_c, b_exp_c;
  bit r_exp_v, b_exp_v, r_ovf_exp, b_ovf_exp;
  int r_pulses = 0, r_credits = 0, r_pops = 0;
  int b_pulses = 0, b_credits = 0, b_pops = 0;

  function automatic void model_clear();
    rq.delete();
    bq.delete();
    r_run = 0; b_run = 0;
    r_exp_v = 0; b_exp_v = 0; r_exp_c = 0; b_exp_c = 0;
    r_ovf_exp = 0; b_ovf_exp = 0;
  endfunction

  // One clock: predict from pre-edge state, advance, then compare at negedge.
  task automatic tick();
    bit r_deq, b_deq, r_ok, b_ok;
    r_deq = 0; b_deq = 0; r_ok = 0; b_ok = 0;
    if (reset_n) begin
      r_deq = (rq.size() != 0) && out_rready;
      b_deq = (bq.size() != 0) && out_bready;
      r_ok  = in_rvalid && ((rq.size() < RD) || r_deq);
      b_ok  = in_bvalid && ((bq.size() < WR) || b_deq);
    end
    @(posedge clk);
    if (reset_n) begin
      if (r_deq) begin void'(rq.pop_front()); r_pops++; end
      if (b_deq) begin void'(bq.pop_front()); b_pops++; end
      if (r_ok) rq.push_back(in_r);
      if (b_ok) bq.push_back(in_b);
`ifdef OFS_PLAT_AXI_RSP_BUF_OVERFLOW_CHECK_EN
      if (in_rvalid && !r_ok) r_ovf_exp = 1;
      if (in_bvalid && !b_ok) b_ovf_exp = 1;
`endif
      r_exp_v = 0; r_exp_c = 0;
      if (r_deq) begin
        r_run++;
        if (r_run % CB == 0) begin r_exp_v = 1; r_exp_c = CB; end
      end else begin
        if (r_run % CB != 0) begin r_exp_v = 1; r_exp_c = r_run % CB; end
        r_run = 0;
      end
      b_exp_v = 0; b_exp_c = 0;
      if (b_deq) begin
        b_run++;
        if (b_run % CB == 0) begin b_exp_v = 1; b_exp_c = CB; end
      end else begin
        if (b_run % CB != 0) begin b_exp_v = 1; b_exp_c = b_run % CB; end
        b_run = 0;
      end
    end else begin
      model_clear();
    end
    @(negedge clk);
    checks++;
    if (out_rvalid !== (rq.size() != 0))
      $display("FAIL out_rvalid t=%0t got %b want %b", $time, out_rvalid, rq.size() != 0);
    else passes++;
    if (rq.size() != 0) begin
      checks++;
      if (out_r !== rq[0]) $display("FAIL out_r t=%0t got %h want %h", $time, out_r, rq[0]);
      else passes++;
    end
    checks++;
    if (out_bvalid !== (bq.size() != 0))
      $display("FAIL out_bvalid t=%0t got %b want %b", $time, out_bvalid, bq.size() != 0);
    else passes++;
    if (bq.size() != 0) begin
      checks++;
      if (out_b !== bq[0]) $display("FAIL out_b t=%0t got %h want %h", $time, out_b, bq[0]);
      else passes++;
    end
    checks++;
    if ({rd_credit_ret_valid, rd_credit_ret_cnt} !== {r_exp_v, CW'(r_exp_c)})
      $display("FAIL rd_credit t=%0t got v=%b c=%0d want v=%b c=%0d", $time,
               rd_credit_ret_valid, rd_credit_ret_cnt, r_exp_v, r_exp_c);
    else passes++;
    checks++;
    if ({wr_credit_ret_valid, wr_credit_ret_cnt} !== {b_exp_v, CW'(b_exp_c)})
      $display("FAIL wr_credit t=%0t got v=%b c=%0d want v=%b c=%0d", $time,
               wr_credit_ret_valid, wr_credit_ret_cnt, b_exp_v, b_exp_c);
    else passes++;
    checks++;
    if ({rd_overflow, wr_overflow} !== {r_ovf_exp, b_ovf_exp})
      $display("FAIL overflow t=%0t got %b%b want %b%b", $time, rd_overflow, wr_overflow,
               r_ovf_exp, b_ovf_exp);
    else passes++;
    if (rd_credit_ret_valid === 1'b1) begin r_pulses++; r_credits += int'(rd_credit_ret_cnt); end
    if (wr_credit_ret_valid === 1'b1) begin b_pulses++; b_credits += int'(wr_credit_ret_cnt); end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    in_rvalid = 0; in_bvalid = 0; in_r = '0; in_b = '0;
  endtask

  task automatic send_r();
    in_rvalid = 1;
    in_r = {$urandom, $urandom};
  endtask

  task automatic send_b();
    in_bvalid = 1;
    in_b = BW'($urandom);
  endtask

  task automatic test_reset();
    int p0;
    reset_n = 0;
    idle_inputs();
    out_rready = 0; out_bready = 0;
    repeat (3) tick();
    reset_n = 1;
    p0 = r_pulses + b_pulses;
    repeat (20) tick();
    checks++;
    if (r_pulses + b_pulses - p0 != 0)
      $display("FAIL idle_pulses got %0d want 0", r_pulses + b_pulses - p0);
    else passes++;
  endtask

  task automatic test_r_burst();
    int p0, c0, q0;
    p0 = r_pulses; c0 = r_credits; q0 = r_pops;
    out_rready = 1;
    for (int i = 0; i < 5; i++) begin
      send_r();
      tick();
      if (i == 0) begin
        checks++;
        if (out_rvalid !== 1'b1) $display("FAIL r_first_latency got %b want 1", out_rvalid);
        else passes++;
      end
    end
    idle_inputs();
    repeat (6) tick();
    checks++;
    if (r_pulses - p0 != 1) $display("FAIL r_burst_pulses got %0d want 1", r_pulses - p0);
    else passes++;
    checks++;
    if (r_credits - c0 != 5) $display("FAIL r_burst_credits got %0d want 5", r_credits - c0);
    else passes++;
    checks++;
    if (r_pops - q0 != 5) $display("FAIL r_burst_pops got %0d want 5", r_pops - q0);
    else passes++;
  endtask

  task automatic test_b_stream();
    int p0, c0;
    p0 = b_pulses; c0 = b_credits;
    out_bready = 1;
    repeat (24) begin send_b(); tick(); end
    idle_inputs();
    repeat (6) tick();
    checks++;
    if (b_pulses - p0 != 3) $display("FAIL b_stream_pulses got %0d want 3", b_pulses - p0);
    else passes++;
    checks++;
    if (b_credits - c0 != 24) $display("FAIL b_stream_credits got %0d want 24", b_credits - c0);
    else passes++;
  endtask

  task automatic test_r_fill_overflow();
    int c0, n;
    out_rready = 0;
    repeat (RD) begin send_r(); tick(); end
`ifndef OFS_PLAT_AXI_RSP_BUF_OVERFLOW_CHECK_EN
    send_r();
    tick();
    checks++;
    if (rd_overflow !== 1'b0) $display("FAIL rd_overflow_off got %b want 0", rd_overflow);
    else passes++;
`endif
    c0 = r_credits;
    // Enqueue coinciding with a pop while full.
    send_r();
    out_rready = 1;
    tick();
    checks++;
    if (rd_overflow !== 1'b0) $display("FAIL full_pop_overflow got %b want 0", rd_overflow);
    else passes++;
    idle_inputs();
    n = 0;
    for (int i = 0; i < RD + 20 && out_rvalid === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != RD) $display("FAIL drain_count got %0d want %0d", n, RD);
    else passes++;
    repeat (3) tick();
    checks++;
    if (r_credits - c0 != RD + 1)
      $display("FAIL fill_credits got %0d want %0d", r_credits - c0, RD + 1);
    else passes++;
  endtask

  task automatic test_random();
    int rc0, bc0, rq0, bq0;
    rc0 = r_credits; bc0 = b_credits; rq0 = r_pops; bq0 = b_pops;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) != 0) send_r(); else in_rvalid = 0;
      if ($urandom_range(0, 2) != 0) send_b(); else in_bvalid = 0;
      out_rready = ($urandom_range(0, 3) != 0);
      out_bready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    out_rready = 1; out_bready = 1;
    repeat (WR + RD + 4) tick();
    checks++;
    if (r_credits - rc0 != r_pops - rq0)
      $display("FAIL rand_r_credits got %0d want %0d", r_credits - rc0, r_pops - rq0);
    else passes++;
    checks++;
    if (b_credits - bc0 != b_pops - bq0)
      $display("FAIL rand_b_credits got %0d want %0d", b_credits - bc0, b_pops - bq0);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int p0;
    out_bready = 0;
    repeat (13) begin send_b(); tick(); end
    idle_inputs();
    out_bready = 1;
    repeat (3) tick();
    out_bready = 0;
    p0 = b_pulses;
    reset_n = 0;
    model_clear();
    #1;
    checks++;
    if (out_bvalid !== 1'b0) $display("FAIL async_reset_bvalid got %b want 0", out_bvalid);
    else passes++;
    repeat (2) tick();
    reset_n = 1;
    repeat (10) tick();
    checks++;
    if (b_pulses - p0 != 0) $display("FAIL post_reset_pulses got %0d want 0", b_pulses - p0);
    else passes++;
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    out_rready = 0;
    out_bready = 0;
    model_clear();
    test_reset();
    test_r_burst();
    test_b_stream();
    test_r_fill_overflow();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
